// File: rtl/addern_seq.sv
// Multi-cycle N-bit adder/subtractor: W bits per clock, LSB chunk first, valid/ready on both sides.
// Define ADDERN_SEQ_OVERFLOW_EN to add the signed-overflow output.
module addern_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out
`ifdef ADDERN_SEQ_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    localparam int NCHUNK = N / W;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    generate
        if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
            $error("addern_seq: need 1 <= W <= N and N %% W == 0");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  a_reg, b_reg, sum_reg;
    logic          carry_reg, c_out_reg;
    logic [KW-1:0] k_reg;
    logic [W-1:0]  a_chunk, b_chunk, s_chunk;
    logic          cy;

    // b_reg already holds ~b for subtraction, so BUSY only ever adds.
    assign a_chunk = a_reg[int'(k_reg) * W +: W];
    assign b_chunk = b_reg[int'(k_reg) * W +: W];
    assign {cy, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, carry_reg};

    assign sum   = sum_reg;
    assign c_out = c_out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (k_reg == K_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            c_out_reg <= 1'b0;
            k_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : c_in;
                        k_reg     <= '0;
                    end
                end
                BUSY: begin
                    sum_reg[int'(k_reg) * W +: W] <= s_chunk;
                    carry_reg <= cy;
                    // Wrap k on the last chunk so the chunk select never leaves the operand.
                    if (k_reg == K_LAST) begin
                        c_out_reg <= cy;
                        k_reg     <= '0;
                    end else begin
                        k_reg <= k_reg + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDERN_SEQ_OVERFLOW_EN
    logic msb_cin;
    logic overflow_reg;

    // Carry into the MSB recovered from the final chunk's top-bit sum.
    assign msb_cin  = a_chunk[W-1] ^ b_chunk[W-1] ^ s_chunk[W-1];
    assign overflow = overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (state_reg == BUSY && k_reg == K_LAST) begin
            overflow_reg <= msb_cin ^ cy;
        end
    end
`endif

endmodule
